// File: rtl/xregf_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xregf_mp_pkg
// Purpose  : Shared defaults and sweep-FSM state encodings for the xregf_mp
//            register file and its clear sequencer.
//            DATA_W / REGF_ADDR_W macros supply the default entry width and
//            address width. c_ST_* are the sweep FSM state codes.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef XDEFS_VH
`define XDEFS_VH
`define DATA_W      32
`define REGF_ADDR_W 4
`endif

package xregf_mp_pkg;

    // Sweep FSM encodings.
    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_CLEAR = 1'b1;

    localparam int c_BYTE_W = 8;

endpackage

`default_nettype wire

// File: rtl/xregf_clr.sv
`default_nettype none
// ============================================================================
// Module   : xregf_clr
// Purpose  : Zero-sweep sequencer for the register file. On reset, or on a
//            clear request while idle, it walks every entry once. It issues
//            one zero write per cycle, then pulses clr_done.
// Ports    : clk, rst_n     - clock, synchronous active-low reset
//            clr_req        - start a sweep (ignored while sweeping)
//            busy           - sweep in progress
//            clr_addr       - entry being zeroed this cycle
//            clr_we         - zero-write enable for clr_addr
//            clr_done       - one-cycle pulse after the last entry is written
// Revision : 1.0 - initial release
// ============================================================================
module xregf_clr
    import xregf_mp_pkg::*;
#(
    parameter int ADDR_W = `REGF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] c_LAST = '1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_done;

    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_done_nxt;
    logic              w_clr_we;

    // Reset lands in CLEAR so the array is zeroed before first use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_clr_we    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_CLEAR: begin
                w_clr_we  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign busy     = (r_state == c_ST_CLEAR);
    assign clr_addr = r_cnt;
    assign clr_we   = w_clr_we;
    assign clr_done = r_done;

endmodule

`default_nettype wire

// File: rtl/xregf_mp.sv
`default_nettype none
// ============================================================================
// Module   : xregf_mp
// Purpose  : DEPTH x DATA_W register file with one byte-strobed write port
//            and two registered read ports. A same-cycle write is bypassed
//            to the read ports (write-first). A sweep clears the array on
//            reset or on request.
// Ports    : clk, rst_n               - clock, synchronous active-low reset
//            sel                      - block select, gates every request
//            we/waddr/wdata/wstrb     - write port with byte strobes
//            ren_a/raddr_a, ren_b/raddr_b - read requests
//            rdata_a, rdata_b         - registered read data (latency 1)
//            clr                      - start a zero sweep
//            busy, clr_done, wr_drop  - sweep status, done pulse, drop pulse
// Revision : 1.0 - initial release
// ============================================================================
module xregf_mp
    import xregf_mp_pkg::*;
#(
    parameter int DATA_W = `DATA_W,
    parameter int ADDR_W = `REGF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                ren_a,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic                ren_b,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [DATA_W-1:0]   rdata_a,
    output logic [DATA_W-1:0]   rdata_b,
    input  logic                clr,
    output logic                busy,
    output logic                clr_done,
    output logic                wr_drop
);

    localparam int c_NBYTES = DATA_W / 8;
    localparam int c_DEPTH  = 1 << ADDR_W;

    // No reset on the array so it can map onto distributed RAM.
    logic [DATA_W-1:0] r_regf [c_DEPTH];

    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;
    logic              r_wr_drop;

    logic              w_busy;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_we;
    logic              w_clr_done;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    xregf_clr #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (sel & clr),
        .busy     (w_busy),
        .clr_addr (w_clr_addr),
        .clr_we   (w_clr_we),
        .clr_done (w_clr_done)
    );

    assign w_wr_en = sel & we & ~w_busy;

    // The sweep owns the single write port while busy; user writes are
    // blocked by w_wr_en, so the two sources never collide.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_regf[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (wstrb[i]) begin
                    r_regf[waddr][i*c_BYTE_W +: c_BYTE_W] <= wdata[i*c_BYTE_W +: c_BYTE_W];
                end
            end
        end
    end

    // Write-first bypass: overlay the strobed bytes of a same-cycle write
    // onto the stored word, independently for each read port.
    always_comb begin
        w_rd_a = r_regf[raddr_a];
        if (w_wr_en && (waddr == raddr_a)) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (wstrb[i]) begin
                    w_rd_a[i*c_BYTE_W +: c_BYTE_W] = wdata[i*c_BYTE_W +: c_BYTE_W];
                end
            end
        end
    end

    always_comb begin
        w_rd_b = r_regf[raddr_b];
        if (w_wr_en && (waddr == raddr_b)) begin
            for (int i = 0; i < c_NBYTES; i++) begin
                if (wstrb[i]) begin
                    w_rd_b[i*c_BYTE_W +: c_BYTE_W] = wdata[i*c_BYTE_W +: c_BYTE_W];
                end
            end
        end
    end

    // During a sweep reads return zero, since the array is partially cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            if (sel && ren_a) begin
                r_rdata_a <= w_busy ? '0 : w_rd_a;
            end
            if (sel && ren_b) begin
                r_rdata_b <= w_busy ? '0 : w_rd_b;
            end
            r_wr_drop <= sel & we & w_busy;
        end
    end

    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign wr_drop  = r_wr_drop;
    assign busy     = w_busy;
    assign clr_done = w_clr_done;

endmodule

`default_nettype wire

// File: tb/tb_xregf_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_xregf_mp
// Purpose  : Scoreboard bench for xregf_mp (DATA_W=32, ADDR_W=4). The driver
//            pushes hand-computed read results and expected drop pulses.
//            A monitor pops and compares them after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xregf_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        ren_a = 1'b0;
    logic [3:0]  raddr_a = '0;
    logic        ren_b = 1'b0;
    logic [3:0]  raddr_b = '0;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        clr = 1'b0;
    logic        busy;
    logic        clr_done;
    logic        wr_drop;

    int total = 0;
    int bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        qd[$];

    logic mon_a;
    logic mon_b;

    xregf_mp #(
        .DATA_W (32),
        .ADDR_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .ren_a    (ren_a),
        .raddr_a  (raddr_a),
        .ren_b    (ren_b),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .clr      (clr),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: reads issued at an edge deliver data just after that edge.
    always begin
        @(posedge clk);
        mon_a = sel && ren_a && rst_n;
        mon_b = sel && ren_b && rst_n;
        #2;
        if (mon_a) begin
            if (qa.size() == 0) chk("rdata_a_unexpected", rdata_a, 32'hxxxxxxxx);
            else chk("rdata_a", rdata_a, qa.pop_front());
        end
        if (mon_b) begin
            if (qb.size() == 0) chk("rdata_b_unexpected", rdata_b, 32'hxxxxxxxx);
            else chk("rdata_b", rdata_b, qb.pop_front());
        end
        if (wr_drop === 1'b1) begin
            if (qd.size() == 0) chk("wr_drop_unexpected", {31'd0, wr_drop}, 32'd0);
            else chk("wr_drop", {31'd0, wr_drop}, {31'd0, qd.pop_front()});
        end
    end

    initial begin
        int n;

        // Reset state.
        repeat (3) tick();
        chk("rst_rdata_a", rdata_a, 32'd0);
        chk("rst_rdata_b", rdata_b, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
        chk("rst_wr_drop", {31'd0, wr_drop}, 32'd0);

        // Power-on sweep: busy for 16 cycles, then a one-cycle done pulse.
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("init_sweep_len", n, 32'd16);
        chk("init_done_pulse", {31'd0, clr_done}, 32'd1);
        sel = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ren_a = 1'b1; raddr_a = 4'(i); qa.push_back(32'd0);
            ren_b = 1'b1; raddr_b = 4'(15 - i); qb.push_back(32'd0);
            tick();
            if (i == 0) chk("init_done_end", {31'd0, clr_done}, 32'd0);
        end
        ren_a = 1'b0; ren_b = 1'b0;

        // Byte-strobe merge.
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wstrb = 4'b1111; tick();
        wdata = 32'h000000AA; wstrb = 4'b0001; tick();
        wdata = 32'h00550000; wstrb = 4'b0100; tick();
        we = 1'b0;
        ren_a = 1'b1; raddr_a = 4'd3; qa.push_back(32'hDE55BEAA); tick();
        ren_a = 1'b0;

        // Same-cycle write with both ports reading it.
        we = 1'b1; waddr = 4'd5; wdata = 32'h12345678; wstrb = 4'b1111;
        ren_a = 1'b1; raddr_a = 4'd5; qa.push_back(32'h12345678);
        ren_b = 1'b1; raddr_b = 4'd5; qb.push_back(32'h12345678);
        tick();
        // Partial-strobe bypass on A only; B reads another address.
        wdata = 32'h00009900; wstrb = 4'b0010;
        qa.push_back(32'h12349978);
        raddr_b = 4'd3; qb.push_back(32'hDE55BEAA);
        tick();
        we = 1'b0; ren_a = 1'b0; ren_b = 1'b0;

        // Deselected requests have no effect.
        sel = 1'b0; we = 1'b1; waddr = 4'd3; wdata = 32'h0; wstrb = 4'b1111;
        ren_a = 1'b1; raddr_a = 4'd0; clr = 1'b1;
        tick(); tick();
        chk("sel0_busy", {31'd0, busy}, 32'd0);
        chk("sel0_rdata_a", rdata_a, 32'h12349978);
        we = 1'b0; ren_a = 1'b0; clr = 1'b0; sel = 1'b1;
        ren_a = 1'b1; raddr_a = 4'd3; qa.push_back(32'hDE55BEAA); tick();
        ren_a = 1'b0;

        // Fill everything, then clear with a write, a read and a clr mid-sweep.
        we = 1'b1; wstrb = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            waddr = 4'(i); wdata = 32'hC0DE0000 + i; tick();
        end
        we = 1'b0;
        ren_a = 1'b1; raddr_a = 4'd9; qa.push_back(32'hC0DE0009);
        ren_b = 1'b1; raddr_b = 4'd15; qb.push_back(32'hC0DE000F);
        tick();
        ren_a = 1'b0; ren_b = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 40) begin
            if (n == 2) begin
                we = 1'b1; waddr = 4'd4; wdata = 32'hFFFFFFFF; wstrb = 4'b1111;
                qd.push_back(1'b1);
            end
            if (n == 3) begin
                we = 1'b0; clr = 1'b1;
                ren_a = 1'b1; raddr_a = 4'd4; qa.push_back(32'd0);
            end
            if (n == 4) begin ren_a = 1'b0; clr = 1'b0; end
            tick(); n++;
        end
        chk("clr_sweep_len", n, 32'd16);
        chk("clr_done_pulse", {31'd0, clr_done}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            ren_a = 1'b1; raddr_a = 4'(i); qa.push_back(32'd0);
            ren_b = 1'b1; raddr_b = 4'(i); qb.push_back(32'd0);
            tick();
        end
        ren_a = 1'b0; ren_b = 1'b0;

        // Reset in the middle of a sweep restarts it from entry 0.
        we = 1'b1; waddr = 4'd7; wdata = 32'h0BADF00D; wstrb = 4'b1111;
        ren_a = 1'b1; raddr_a = 4'd7; qa.push_back(32'h0BADF00D);
        tick();
        we = 1'b0; ren_a = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0; tick();
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_rdata_a", rdata_a, 32'd0);
        rst_n = 1'b1;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("midrst_sweep_len", n, 32'd16);
        chk("midrst_done_pulse", {31'd0, clr_done}, 32'd1);

        // Partial write onto a cleared entry.
        we = 1'b1; waddr = 4'd2; wdata = 32'hFFFFFF55; wstrb = 4'b0001; tick();
        we = 1'b0;
        ren_b = 1'b1; raddr_b = 4'd2; qb.push_back(32'h00000055); tick();
        ren_b = 1'b0;
        ren_a = 1'b1; raddr_a = 4'd7; qa.push_back(32'd0); tick();
        ren_a = 1'b0;

        tick(); tick();
        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        chk("qd_drained", qd.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/xregf_mp.md
XREGF_MP -- requirements
Module: xregf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default `DATA_W, meaning entry width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default `REGF_ADDR_W, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port sel  input  1  block select; gates all reads and writes.
REQ-006 SHALL have ports we / waddr / wdata / wstrb  input  1 / ADDR_W / DATA_W / DATA_W/8  write enable, address, data, byte strobes.
REQ-007 SHALL have ports ren_a / raddr_a and ren_b / raddr_b  input  1 / ADDR_W each  read enables and addresses, ports A and B.
REQ-008 SHALL have ports rdata_a / rdata_b  output  DATA_W each  registered read data.
REQ-009 SHALL have port clr  input  1  request to zero the whole array.
REQ-010 SHALL have ports busy / clr_done / wr_drop  output  1 each  sweep active, one-cycle sweep-complete pulse, one-cycle dropped-write pulse.

Function
REQ-011 SHALL write, when sel&&we&&!busy, byte i of regf[waddr] from wdata byte i for every set wstrb[i]; unset bytes keep old value.
REQ-012 SHALL, when sel&&ren_p&&!busy, load rdata_p on the next edge with regf[raddr_p] (latency 1); otherwise rdata_p holds.
REQ-013 SHALL bypass: if the same cycle also writes raddr_p, rdata_p gets the strobe-merged new value (write-first), independently per port.
REQ-014 SHALL allow both ports to read the same address in one cycle with identical results.
REQ-015 SHALL run a two-state FSM: IDLE, CLEAR; busy = (state==CLEAR), registered.
REQ-016 SHALL move IDLE->CLEAR on clr=1; counter loads 0; clr is ignored while in CLEAR.
REQ-017 SHALL, in CLEAR, write zero to regf[counter] each cycle and increment counter; at counter==DEPTH-1 write the last entry, go to IDLE and pulse clr_done for exactly one cycle; sweep lasts DEPTH cycles.
REQ-018 SHALL, while busy, load 0 into rdata_p on any sel&&ren_p.
REQ-019 SHALL, while busy, discard any sel&&we and pulse wr_drop one cycle later; wr_drop=0 otherwise.
REQ-020 SHALL ignore we, ren_a, ren_b and clr entirely when sel=0 (no drop pulse).

Reset
REQ-021 SHALL, on rst_n=0 at a rising edge: rdata_a=rdata_b=0, clr_done=0, wr_drop=0, counter=0, state=CLEAR (busy=1).
REQ-022 SHALL, after rst_n releases, complete a full DEPTH-cycle zero sweep, then IDLE with clr_done pulse; array contents are zero only after this.
REQ-023 SHALL restart the sweep from entry 0 on reset asserted mid-sweep or mid-operation.

Structure
REQ-024 SHALL take DATA_W and REGF_ADDR_W defaults and FSM state encodings from the shared xdefs.vh include.
REQ-025 SHALL place the sweep FSM and counter in sub-module xregf_clr (outputs busy, clear address, clear write enable, clr_done).
REQ-026 SHALL keep the array free of reset so it maps to distributed RAM; one write port, two read ports.

Verification (DATA_W=32, ADDR_W=4)
REQ-027 SHALL cover reset release -> busy=1 for 16 cycles, clr_done single pulse, then reads of entries 0..15 all return 0.
REQ-028 SHALL cover write 0xDEADBEEF to addr 3 wstrb=1111, then wdata 0x000000AA wstrb=0001 -> read addr 3 gives 0xDEADBEAA next cycle.
REQ-029 SHALL cover same-cycle write 0x12345678 to addr 5 with ren_a/ren_b on addr 5 -> both rdata equal 0x12345678 one cycle later.
REQ-030 SHALL cover clr pulse after filling all entries, write during sweep -> wr_drop pulse, read during sweep -> 0, after done all entries 0.
REQ-031 SHALL cover rst_n low at sweep counter=7 -> sweep restarts at 0, busy stays high 16 further cycles.
REQ-032 SHALL cover sel=0 with we=1, ren_a=1, clr=1 -> array, rdata_a, busy, wr_drop unchanged.
